// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: requester handshake bundle and BRAM port A wiring.
// master = requesters/BRAM side, slave = arbiter.
interface dmem_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int NB_COL     = 4
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ*NB_COL-1:0]     req_wen;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic [ADDR_WIDTH-1:0]         bram_addr;
  logic [DATA_WIDTH-1:0]         bram_wdata;
  logic [NB_COL-1:0]             bram_wen;
  logic [DATA_WIDTH-1:0]         bram_rdata;

  modport master (
    output req_valid, req_addr, req_wdata,
    output req_wen, req_lock, bram_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  bram_addr, bram_wdata, bram_wen
  );

  modport slave (
    input  req_valid, req_addr, req_wdata,
    input  req_wen, req_lock, bram_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output bram_addr, bram_wdata, bram_wen
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: round-robin share of BRAM port A with atomic lock.
// Define DMEM_ARB_PERF_CNT_EN for per-requester grant/stall counters.
module dmem_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int NB_COL       = 4,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_port_arbiter_if.slave    bus,
  output logic                  lock_err,
  output logic [NUM_REQ*32-1:0] perf_grants,
  output logic [NUM_REQ*32-1:0] perf_stalls
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = $clog2(LOCK_TIMEOUT);

  typedef logic [IW-1:0] idx_t;
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                st, st_n;
  idx_t                  ptr, ptr_n;
  idx_t                  owner, owner_n;
  idx_t                  gnt_idx;
  logic [TW-1:0]         timer, timer_n;
  logic                  gnt_any;
  logic                  acc;
  logic                  lock_to;
  logic                  sel_lock;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [NB_COL-1:0]     sel_wen;

  logic                  s1_v;
  logic                  s1_rd;
  idx_t                  s1_i;
  logic [NUM_REQ-1:0]    s1_oh;
  logic                  s2_rd;
  logic [DATA_WIDTH-1:0] hold;

  function automatic idx_t wrap(input int v);
    return idx_t'(v % NUM_REQ);
  endfunction

  function automatic idx_t inc(input idx_t i);
    return wrap(int'(i) + 1);
  endfunction

  // Descending scan: the lowest offset from ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (st == LOCKED) begin
      gnt_any = bus.req_valid[owner];
      gnt_idx = owner;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (bus.req_valid[wrap(int'(ptr) + k)]) begin
          gnt_any = 1'b1;
          gnt_idx = wrap(int'(ptr) + k);
        end
      end
    end
  end

  assign acc = gnt_any & reset;

  assign sel_addr  = bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = bus.req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_wen   = bus.req_wen[int'(gnt_idx)*NB_COL +: NB_COL];
  assign sel_lock  = bus.req_lock[gnt_idx];

  always_comb begin
    bus.req_ready = '0;
    if (acc) bus.req_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    st_n    = st;
    ptr_n   = ptr;
    owner_n = owner;
    timer_n = timer;
    lock_to = 1'b0;
    unique case (st)
      IDLE: begin
        if (acc) begin
          ptr_n = inc(gnt_idx);
          if (sel_lock) begin
            st_n    = LOCKED;
            owner_n = gnt_idx;
            timer_n = '0;
          end
        end
      end
      LOCKED: begin
        timer_n = timer + 1'b1;
        if (timer == TW'(LOCK_TIMEOUT - 1)) begin
          lock_to = 1'b1;
          st_n    = IDLE;
          ptr_n   = inc(owner);
          timer_n = '0;
        end else if (acc && !sel_lock) begin
          st_n    = IDLE;
          ptr_n   = inc(owner);
          timer_n = '0;
        end
      end
    endcase
  end

  assign lock_err = lock_to & reset;

  always_ff @(posedge clk) begin
    if (!reset) begin
      st    <= IDLE;
      ptr   <= '0;
      owner <= '0;
      timer <= '0;
    end else begin
      st    <= st_n;
      ptr   <= ptr_n;
      owner <= owner_n;
      timer <= timer_n;
    end
  end

  always_comb begin
    s1_oh = '0;
    if (s1_v) s1_oh[s1_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.bram_addr  <= '0;
      bus.bram_wdata <= '0;
      bus.bram_wen   <= '0;
      bus.rsp_valid  <= '0;
      s1_v           <= 1'b0;
      s1_rd          <= 1'b0;
      s1_i           <= '0;
      s2_rd          <= 1'b0;
      hold           <= '0;
    end else begin
      bus.bram_wen <= acc ? sel_wen : '0;
      if (acc) begin
        bus.bram_addr  <= sel_addr;
        bus.bram_wdata <= sel_wdata;
      end
      s1_v          <= acc;
      s1_rd         <= ~|sel_wen;
      s1_i          <= gnt_idx;
      bus.rsp_valid <= s1_oh;
      s2_rd         <= s1_v & s1_rd;
      hold          <= bus.rsp_rdata;
    end
  end

  // BRAM doa is only meaningful in the read-response cycle.
  assign bus.rsp_rdata = s2_rd ? bus.bram_rdata : hold;

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] gcnt [NUM_REQ];
  logic [31:0] scnt [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!reset) begin
        gcnt[i] <= '0;
        scnt[i] <= '0;
      end else begin
        if (bus.req_ready[i] && gcnt[i] != '1)
          gcnt[i] <= gcnt[i] + 1'b1;
        if (bus.req_valid[i] && !bus.req_ready[i] && scnt[i] != '1)
          scnt[i] <= scnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    perf_grants = '0;
    perf_stalls = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      perf_grants[i*32 +: 32] = gcnt[i];
      perf_stalls[i*32 +: 32] = scnt[i];
    end
  end
`else
  assign perf_grants = '0;
  assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios plus random traffic
// against a cycle-level behavioural model of the arbiter.
module tb_dmem_port_arbiter;
  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int TO = 8;
`ifdef DMEM_ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic lock_err;
  logic [N*32-1:0] perf_grants;
  logic [N*32-1:0] perf_stalls;

  always #5 clk = ~clk;

  dmem_port_arbiter_if #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_COL(NB)
  ) bus ();

  dmem_port_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NB_COL(NB), .LOCK_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .lock_err(lock_err),
    .perf_grants(perf_grants),
    .perf_stalls(perf_stalls)
  );

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old, input logic [DW-1:0] nw,
    input logic [NB-1:0] we);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < NB; b++)
      if (we[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // Write-first BRAM, one-cycle read latency.
  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge clk) begin
    bram[bus.bram_addr] <= merge(bram[bus.bram_addr], bus.bram_wdata, bus.bram_wen);
    bus.bram_rdata <= merge(bram[bus.bram_addr], bus.bram_wdata, bus.bram_wen);
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  bit            pend [N];
  logic [AW-1:0] a    [N];
  logic [DW-1:0] d    [N];
  logic [NB-1:0] we   [N];
  bit            lk   [N];
  bit            rst_req;

  logic [DW-1:0] refm [0:(1<<AW)-1];
  int            rr, mo, mcyc;
  bit            ml;
  bit            s1_v, s1_rd, s2_v, s2_rd;
  int            s1_i, s2_i;
  logic [DW-1:0] s1_dat, s2_dat, e_hold;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [NB-1:0] e_wen;
  logic [31:0]   gcnt [N];
  logic [31:0]   scnt [N];

  logic [N-1:0]  last_rv, last_rdy;
  logic [DW-1:0] last_rd;
  logic [AW-1:0] last_addr;
  logic [NB-1:0] last_wen;
  logic          last_le;
  int            le_seen = 0;

  task automatic model_reset();
    rr = 0; ml = 0; mo = 0; mcyc = 0;
    s1_v = 0; s2_v = 0; s1_rd = 0; s2_rd = 0;
    s1_i = 0; s2_i = 0; s1_dat = '0; s2_dat = '0;
    e_addr = '0; e_wdata = '0; e_wen = '0; e_hold = '0;
    for (int i = 0; i < N; i++) begin
      gcnt[i] = '0; scnt[i] = '0; pend[i] = 0;
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] ad,
                         input logic [DW-1:0] dd, input logic [NB-1:0] ww,
                         input bit ll);
    pend[i] = 1; a[i] = ad; d[i] = dd; we[i] = ww; lk[i] = ll;
  endtask

  task automatic step();
    int g;
    logic [N-1:0] er;
    logic [N-1:0] ev;
    bit eto;
    @(negedge clk);
    last_rv   = bus.rsp_valid;
    last_rd   = bus.rsp_rdata;
    last_addr = bus.bram_addr;
    last_wen  = bus.bram_wen;
    chk("bram_addr", 64'(bus.bram_addr), 64'(e_addr));
    chk("bram_wdata", 64'(bus.bram_wdata), 64'(e_wdata));
    chk("bram_wen", 64'(bus.bram_wen), 64'(e_wen));
    ev = '0;
    if (s2_v) ev[s2_i] = 1'b1;
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
    if (s2_v && s2_rd) e_hold = s2_dat;
    if (!(s2_v && !s2_rd))
      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e_hold));
    for (int i = 0; i < N; i++) begin
      chk("perf_grants", 64'(perf_grants[i*32 +: 32]), 64'(PERF ? gcnt[i] : 32'h0));
      chk("perf_stalls", 64'(perf_stalls[i*32 +: 32]), 64'(PERF ? scnt[i] : 32'h0));
    end

    reset = ~rst_req;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]          = pend[i] && !rst_req;
      bus.req_addr[i*AW +: AW]  = a[i];
      bus.req_wdata[i*DW +: DW] = d[i];
      bus.req_wen[i*NB +: NB]   = we[i];
      bus.req_lock[i]           = lk[i];
    end
    #1;

    g = -1;
    if (!rst_req) begin
      if (ml) begin
        if (pend[mo]) g = mo;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && pend[(rr + k) % N]) g = (rr + k) % N;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    // The TO-th cycle of ownership forces release.
    eto = !rst_req && ml && (mcyc + 1 == TO);
    last_rdy = bus.req_ready;
    last_le  = lock_err;
    if (lock_err === 1'b1) le_seen++;
    chk("req_ready", 64'(bus.req_ready), 64'(er));
    chk("lock_err", 64'(lock_err), 64'(eto));

    if (rst_req) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++)
        if (pend[i] && i != g && scnt[i] != '1) scnt[i]++;
      s2_v = s1_v; s2_i = s1_i; s2_rd = s1_rd; s2_dat = s1_dat;
      s1_v = (g >= 0);
      e_wen = '0;
      if (g >= 0) begin
        if (gcnt[g] != '1) gcnt[g]++;
        s1_i   = g;
        s1_rd  = (we[g] == '0);
        s1_dat = refm[a[g]];
        refm[a[g]] = merge(refm[a[g]], d[g], we[g]);
        e_addr  = a[g];
        e_wdata = d[g];
        e_wen   = we[g];
        pend[g] = 0;
      end
      if (!ml) begin
        if (g >= 0) begin
          rr = (g + 1) % N;
          if (lk[g]) begin
            ml = 1; mo = g; mcyc = 0;
          end
        end
      end else begin
        mcyc++;
        if (mcyc == TO || (g >= 0 && !lk[g])) begin
          ml = 0;
          rr = (mo + 1) % N;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    int iss [2];
    int base, first_le, g0;
    for (int i = 0; i < (1<<AW); i++) begin
      refm[i] = $urandom;
      bram[i] = refm[i];
    end
    refm[5]  = 32'hDEADBEEF; bram[5]  = 32'hDEADBEEF;
    refm[16] = 32'h11223344; bram[16] = 32'h11223344;
    for (int i = 0; i < N; i++) begin
      a[i] = '0; d[i] = '0; we[i] = '0; lk[i] = 0;
    end
    bus.req_valid = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_wen = '0; bus.req_lock = '0;
    rst_req = 0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    model_reset();
    idle(2);

    // Contention: grants alternate 0,1,0,1.
    iss[0] = 0; iss[1] = 0;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && iss[i] < 2) begin
          set_req(i, AW'(40 + s*2 + i), $urandom, '0, 0);
          iss[i]++;
        end
      step();
      chk("cont_gnt", 64'(last_rdy), (s % 2 == 0) ? 64'h1 : 64'h2);
    end
    idle(3);

    // Single read of a preloaded word.
    set_req(0, AW'(5), $urandom, '0, 0);
    step();
    chk("rd_ready", 64'(last_rdy), 64'h1);
    step();
    chk("rd_bram_addr", 64'(last_addr), 64'h5);
    step();
    chk("rd_rsp_valid", 64'(last_rv), 64'h1);
    chk("rd_rdata", 64'(last_rd), 64'hDEADBEEF);
    idle(2);

    // Byte write followed by read-back.
    set_req(1, AW'(16), 32'h000000AA, 4'b0001, 0);
    step();
    chk("bw_ready", 64'(last_rdy), 64'h2);
    set_req(1, AW'(16), $urandom, '0, 0);
    step();
    chk("br_ready", 64'(last_rdy), 64'h2);
    step();
    step();
    chk("br_rsp_valid", 64'(last_rv), 64'h2);
    chk("br_rdata", 64'(last_rd), 64'h112233AA);
    idle(2);

    // Lock held for three accesses while req0 waits.
    base = le_seen;
    set_req(1, AW'(20), $urandom, '0, 1);
    step();
    chk("lk_first", 64'(last_rdy), 64'h2);
    set_req(0, AW'(21), $urandom, '0, 0);
    set_req(1, AW'(22), $urandom, 4'hF, 1);
    step();
    chk("lk_second", 64'(last_rdy), 64'h2);
    set_req(1, AW'(23), $urandom, '0, 0);
    step();
    chk("lk_third", 64'(last_rdy), 64'h2);
    step();
    chk("lk_req0_after", 64'(last_rdy), 64'h1);
    chk("lk_no_err", 64'(le_seen - base), 64'h0);
    idle(2);

    // Lock abandoned by its owner.
    set_req(1, AW'(24), $urandom, '0, 1);
    step();
    chk("to_lock_gnt", 64'(last_rdy), 64'h2);
    set_req(0, AW'(25), $urandom, '0, 0);
    base = le_seen; first_le = -1; g0 = -1;
    for (int s = 1; s <= 12; s++) begin
      step();
      if (last_le === 1'b1 && first_le < 0) first_le = s;
      if (last_rdy[0] === 1'b1 && g0 < 0) g0 = s;
    end
    chk("to_err_cycle", 64'(first_le), 64'd8);
    chk("to_err_count", 64'(le_seen - base), 64'd1);
    chk("to_req0_cycle", 64'(g0), 64'd9);
    idle(2);

    // Reset right after a read is accepted.
    set_req(0, AW'(5), $urandom, '0, 0);
    step();
    chk("rst_rd_ready", 64'(last_rdy), 64'h1);
    rst_req = 1;
    step();
    rst_req = 0;
    step();
    chk("rst_no_rsp", 64'(last_rv), 64'h0);
    chk("rst_wen", 64'(last_wen), 64'h0);
    step();
    chk("rst_no_rsp_late", 64'(last_rv), 64'h0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0)
          set_req(i, AW'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 1) == 1) ? NB'($urandom) : '0,
                  $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) rst_req = 1;
      step();
      rst_req = 0;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
